// File: rtl/fp_normalize_round.sv
// -----------------------------------------------------------------------------
// fp_normalize_round
//   Post-adder normalise/round stage for half-precision results. It takes the
//   adder's raw sign, biased exponent and unnormalised fraction, then produces
//   a normalised, rounded {sign, exp, mant} word. A carry out of the fraction
//   is handled in a single step: a right shift with round-to-nearest-even.
//   Leading zeros are removed by an iterative left shift, one bit per clock.
//
//   All state changes on the falling edge of clk, which matches the adder's
//   operand registers.
//
// Ports
//   clk       : clock (falling edge active)
//   reset     : asynchronous active-low reset
//   start     : request, sampled only while idle
//   signIn    : result sign from the adder
//   expIn     : biased exponent from the adder (bias 15)
//   fracIn    : {carry, hidden, mantissa} unnormalised fraction
//   busy      : operation in progress (check / shift / done phases)
//   done      : one-cycle pulse, result and flags valid
//   result    : {sign, exp, mant}, held until the next done
//   overflow  : result saturated to infinity
//   underflow : result flushed to zero
// -----------------------------------------------------------------------------
module fp_normalize_round #(
   parameter int FRAC_W     = 12,
   parameter int EXP_W      = 5,
   parameter int MAX_LSHIFT = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      signIn,
   input  logic [EXP_W-1:0]          expIn,
   input  logic [FRAC_W-1:0]         fracIn,
   output logic                      busy,
   output logic                      done,
   output logic [EXP_W+FRAC_W-2:0]   result,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int MANT_W = FRAC_W - 2;
   // One spare exponent bit so that the +2 of a rounding carry cannot wrap.
   localparam int XW     = EXP_W + 1;
   localparam int CNT_W  = $clog2(MAX_LSHIFT + 1);

   localparam logic [XW-1:0]     EXP_ONE  = XW'(1);
   localparam logic [XW-1:0]     EXP_TWO  = XW'(2);
   localparam logic [XW-1:0]     EXP_INF  = XW'((1 << EXP_W) - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_LSHIFT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      SHIFTL = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t               state_r;
   logic                 sign_r;
   logic [XW-1:0]        exp_r;
   logic [FRAC_W-1:0]    frac_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 ovf_r;
   logic                 unf_r;

   logic [FRAC_W-1:0]    rsh_s;
   logic                 rnd_bit_s;
   logic [FRAC_W-1:0]    rnd_s;
   logic [FRAC_W-1:0]    rn_frac_s;
   logic [XW-1:0]        rn_exp_s;
   logic [FRAC_W-1:0]    lsh_frac_s;
   logic [XW-1:0]        lsh_exp_s;
   logic [CNT_W-1:0]     cnt_inc_s;

   // Datapath candidates: carry right shift with rounding, and one left-shift step.
   always_comb begin
      // The bit shifted out is the guard; round up only on a tie with odd LSB,
      // which for a single dropped bit is guard & new LSB.
      rsh_s     = frac_r >> 1;
      rnd_bit_s = frac_r[0] & frac_r[1];
      rnd_s     = rsh_s + {{(FRAC_W-1){1'b0}}, rnd_bit_s};
      // Rounding can carry back into the top bit (all-ones mantissa); the
      // renormalising shift drops only a zero, so no second rounding is needed.
      if (rnd_s[FRAC_W-1]) begin
         rn_frac_s = rnd_s >> 1;
         rn_exp_s  = exp_r + EXP_TWO;
      end else begin
         rn_frac_s = rnd_s;
         rn_exp_s  = exp_r + EXP_ONE;
      end
      lsh_frac_s = frac_r << 1;
      lsh_exp_s  = exp_r - EXP_ONE;
      cnt_inc_s  = cnt_r + CNT_ONE;
   end

   // Control FSM with registered datapath state and registered outputs.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         sign_r    <= 1'b0;
         exp_r     <= {XW{1'b0}};
         frac_r    <= {FRAC_W{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         ovf_r     <= 1'b0;
         unf_r     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= {(EXP_W+FRAC_W-1){1'b0}};
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  sign_r    <= signIn;
                  exp_r     <= {1'b0, expIn};
                  frac_r    <= fracIn;
                  cnt_r     <= {CNT_W{1'b0}};
                  ovf_r     <= 1'b0;
                  unf_r     <= 1'b0;
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
                  busy      <= 1'b1;
                  state_r   <= CHECK;
               end else begin
                  state_r   <= IDLE;
               end
            end

            CHECK: begin
               if (frac_r == {FRAC_W{1'b0}}) begin
                  // Exact zero always comes out as +0.
                  sign_r  <= 1'b0;
                  exp_r   <= {XW{1'b0}};
                  state_r <= DONE;
               end else if (exp_r == EXP_INF) begin
                  exp_r   <= EXP_INF;
                  frac_r  <= {FRAC_W{1'b0}};
                  ovf_r   <= 1'b1;
                  state_r <= DONE;
               end else if (frac_r[FRAC_W-1]) begin
                  if (rn_exp_s >= EXP_INF) begin
                     exp_r  <= EXP_INF;
                     frac_r <= {FRAC_W{1'b0}};
                     ovf_r  <= 1'b1;
                  end else begin
                     exp_r  <= rn_exp_s;
                     frac_r <= rn_frac_s;
                  end
                  state_r <= DONE;
               end else if (frac_r[FRAC_W-2]) begin
                  state_r <= DONE;
               end else begin
                  state_r <= SHIFTL;
               end
            end

            SHIFTL: begin
               if ((exp_r <= EXP_ONE) || (cnt_r >= CNT_MAX)) begin
                  // No room left to shift: flush to +0.
                  sign_r  <= 1'b0;
                  exp_r   <= {XW{1'b0}};
                  frac_r  <= {FRAC_W{1'b0}};
                  unf_r   <= 1'b1;
                  state_r <= DONE;
               end else if (lsh_frac_s[FRAC_W-2]) begin
                  frac_r  <= lsh_frac_s;
                  exp_r   <= lsh_exp_s;
                  cnt_r   <= cnt_inc_s;
                  state_r <= DONE;
               end else if ((lsh_exp_s <= EXP_ONE) || (cnt_inc_s >= CNT_MAX)) begin
                  // This shift leaves the exponent at its floor while still
                  // unnormalised, so the next step would flush anyway; flush now.
                  sign_r  <= 1'b0;
                  exp_r   <= {XW{1'b0}};
                  frac_r  <= {FRAC_W{1'b0}};
                  cnt_r   <= cnt_inc_s;
                  unf_r   <= 1'b1;
                  state_r <= DONE;
               end else begin
                  frac_r  <= lsh_frac_s;
                  exp_r   <= lsh_exp_s;
                  cnt_r   <= cnt_inc_s;
                  state_r <= SHIFTL;
               end
            end

            DONE: begin
               result    <= {sign_r, exp_r[EXP_W-1:0], frac_r[MANT_W-1:0]};
               overflow  <= ovf_r;
               underflow <= unf_r;
               done      <= 1'b1;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end

            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_normalize_round.sv
module tb_fp_normalize_round;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        signIn = 1'b0;
   logic [4:0]  expIn = 5'd0;
   logic [11:0] fracIn = 12'd0;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        overflow;
   logic        underflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fp_normalize_round dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .signIn    (signIn),
      .expIn     (expIn),
      .fracIn    (fracIn),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow)
   );

   typedef struct {
      logic        s;
      logic [4:0]  e;
      logic [11:0] f;
      logic [15:0] r;
      logic        ov;
      logic        un;
      int          lat;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model from the arithmetic rules: value-level rounding and
   // leading-zero counting, latency as 2 cycles plus one per shift.
   function automatic void model(input logic s, input logic [4:0] e, input logic [11:0] f,
                                 output logic [15:0] r, output logic ov, output logic un,
                                 output int lat);
      int q, x, k, m;
      ov = 1'b0; un = 1'b0; lat = 2; r = 16'h0000;
      if (f == 12'd0) begin
         r = 16'h0000;
      end else if (e == 5'd31) begin
         r = {s, 5'h1f, 10'h000}; ov = 1'b1;
      end else if (int'(f) >= 2048) begin
         q = int'(f) / 2;
         if ((int'(f) % 2 == 1) && (q % 2 == 1)) q++;
         x = int'(e) + 1;
         if (q >= 2048) begin q = q / 2; x++; end
         if (x >= 31) begin r = {s, 5'h1f, 10'h000}; ov = 1'b1; end
         else r = {s, 5'(x), 10'(q % 1024)};
      end else if (int'(f) >= 1024) begin
         r = {s, e, f[9:0]};
      end else begin
         k = 0; m = int'(f);
         while (m < 1024) begin m = m * 2; k++; end
         if (int'(e) - k >= 1) begin
            r = {s, 5'(int'(e) - k), 10'(m % 1024)};
            lat = 2 + k;
         end else begin
            r = 16'h0000; un = 1'b1;
            lat = (e > 5'd1) ? (1 + int'(e)) : 3;
         end
      end
   endfunction

   // One operation: accept, optionally keep start high for 'hold' cycles
   // (including the done edge), scramble inputs while busy, then check.
   task automatic run_op(input string name, input logic s, input logic [4:0] e, input logic [11:0] f,
                         input logic [15:0] er, input logic eo, input logic eu, input int elat,
                         input int hold);
      int n;
      @(posedge clk);
      signIn = s; expIn = e; fracIn = f; start = 1'b1;
      @(negedge clk); #1;
      check({name, ".busy_acc"}, busy, 1'b1);
      check({name, ".flags_clr"}, {overflow, underflow}, 2'b00);
      n = 0;
      while (n < 40) begin
         start  = (n < hold) ? 1'b1 : 1'b0;
         signIn = 1'($urandom);
         expIn  = 5'($urandom);
         fracIn = 12'($urandom);
         @(negedge clk); #1;
         n++;
         if (done) break;
      end
      check({name, ".latency"}, n, elat);
      check({name, ".result"}, result, er);
      check({name, ".ovf"}, overflow, eo);
      check({name, ".unf"}, underflow, eu);
      check({name, ".busy_end"}, busy, 1'b0);
      start = 1'b0;
      @(negedge clk); #1;
      check({name, ".done_pulse"}, {done, busy}, 2'b00);
      check({name, ".hold_res"}, result, er);
   endtask

   initial begin
      logic [15:0] mr;
      logic        mo, mu;
      int          ml, pulses;
      logic        rs;
      logic [4:0]  re;
      logic [11:0] rf;

      tbl[0]  = '{1'b0, 5'd17, 12'h690, 16'h4690, 1'b0, 1'b0, 2};
      tbl[1]  = '{1'b0, 5'd17, 12'h270, 16'h40E0, 1'b0, 1'b0, 3};
      tbl[2]  = '{1'b0, 5'd17, 12'h801, 16'h4800, 1'b0, 1'b0, 2};
      tbl[3]  = '{1'b0, 5'd17, 12'h803, 16'h4802, 1'b0, 1'b0, 2};
      tbl[4]  = '{1'b0, 5'd17, 12'hFFF, 16'h4C00, 1'b0, 1'b0, 2};
      tbl[5]  = '{1'b0, 5'd30, 12'h800, 16'h7C00, 1'b1, 1'b0, 2};
      tbl[6]  = '{1'b1, 5'd17, 12'h000, 16'h0000, 1'b0, 1'b0, 2};
      tbl[7]  = '{1'b0, 5'd3,  12'h004, 16'h0000, 1'b0, 1'b1, 4};
      tbl[8]  = '{1'b0, 5'd20, 12'h001, 16'h2800, 1'b0, 1'b0, 12};
      tbl[9]  = '{1'b1, 5'd31, 12'h500, 16'hFC00, 1'b1, 1'b0, 2};
      tbl[10] = '{1'b1, 5'd1,  12'h200, 16'h0000, 1'b0, 1'b1, 3};
      tbl[11] = '{1'b1, 5'd29, 12'hC01, 16'hFA00, 1'b0, 1'b0, 2};
      tbl[12] = '{1'b0, 5'd29, 12'hFFF, 16'h7C00, 1'b1, 1'b0, 2};

      // Reset state
      #12;
      check("rst.outputs", {busy, done, overflow, underflow, result}, 20'h00000);
      @(posedge clk);
      reset = 1'b1;

      // Directed table
      for (int i = 0; i < 13; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].e, tbl[i].f,
                tbl[i].r, tbl[i].ov, tbl[i].un, tbl[i].lat, 0);
      end

      // start held while busy and on the done edge: must be ignored
      run_op("hold", 1'b0, 5'd17, 12'h270, 16'h40E0, 1'b0, 1'b0, 3, 10);
      @(negedge clk); #1;
      check("hold.no_reaccept", busy, 1'b0);

      // Reset in the middle of a long left-shift sequence
      @(posedge clk);
      signIn = 1'b0; expIn = 5'd20; fracIn = 12'h001; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("rstmid.busy_pre", busy, 1'b1);
      reset = 1'b0;
      #1;
      check("rstmid.outputs", {busy, done, overflow, underflow, result}, 20'h00000);
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;
      pulses = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk); #1;
         if (done || busy) pulses++;
      end
      check("rstmid.no_done", pulses, 0);
      run_op("after_rst", 1'b0, 5'd17, 12'h690, 16'h4690, 1'b0, 1'b0, 2, 0);

      // Randomised against the reference model
      for (int i = 0; i < 150; i++) begin
         rs = 1'($urandom);
         re = 5'($urandom);
         rf = 12'($urandom) >> $urandom_range(0, 11);
         model(rs, re, rf, mr, mo, mu, ml);
         run_op($sformatf("rnd%0d", i), rs, re, rf, mr, mo, mu, ml, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
